id_stage_sb: RTL

- Parametrised instruction-decode stage for the RV32I-subset ALU pipeline.
- Decodes full 32-bit instructions and reads an NREG x XLEN register file with write-first bypass.
- Tracks in-flight loads with a per-register scoreboard and stalls any consumer until its load writes back, independent of load latency.
- Sits between the fetch stage and the execute stage; outputs are registered, latency 1 cycle.

---
 rtl/id_stage_sb.sv | 227 ++++++++++++++++++++++
 1 files changed

// File: rtl/id_stage_sb.sv
`default_nettype none
// ============================================================================
// Module   : id_stage_sb
// Brief    : RV32I-subset instruction decode stage. Write-first register
//            file, per-register load scoreboard with hazard stall, and
//            registered decode outputs (latency 1).
// Revision : 1.0 - initial release
// ============================================================================
module id_stage_sb #(
    parameter int XLEN = 32,
    parameter int NREG = 32,
    parameter int PC_W = 32,
    localparam int AW  = $clog2(NREG)
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [31:0]     in_instr,
    input  logic [PC_W-1:0] in_pc,
    input  logic            in_pred_taken,
    input  logic            flush,
    input  logic            mem_stall,
    input  logic            wb_en,
    input  logic [AW-1:0]   wb_addr,
    input  logic [XLEN-1:0] wb_data,
    input  logic            wb_is_load,
    output logic            out_valid,
    output logic [AW-1:0]   out_rd,
    output logic [AW-1:0]   out_rs1,
    output logic [AW-1:0]   out_rs2,
    output logic [XLEN-1:0] out_rs1_data,
    output logic [XLEN-1:0] out_rs2_data,
    output logic [XLEN-1:0] out_imm,
    output logic [3:0]      out_alu_op,
    output logic            out_alu_src,
    output logic            out_mem_rd,
    output logic            out_mem_wr,
    output logic            out_reg_wr,
    output logic            out_is_branch,
    output logic [1:0]      out_br_type,
    output logic [PC_W-1:0] out_pc,
    output logic            out_pred_taken,
    output logic            out_illegal
);

    localparam logic [6:0] c_OP_R      = 7'b0110011;
    localparam logic [6:0] c_OP_IMM    = 7'b0010011;
    localparam logic [6:0] c_OP_LOAD   = 7'b0000011;
    localparam logic [6:0] c_OP_STORE  = 7'b0100011;
    localparam logic [6:0] c_OP_BRANCH = 7'b1100011;
    localparam logic [6:0] c_OP_JAL    = 7'b1101111;
    localparam logic [6:0] c_OP_JALR   = 7'b1100111;

    localparam logic [3:0] c_ALU_ADD = 4'd0;
    localparam logic [3:0] c_ALU_SUB = 4'd1;
    localparam logic [3:0] c_ALU_AND = 4'd2;
    localparam logic [3:0] c_ALU_OR  = 4'd3;
    localparam logic [3:0] c_ALU_XOR = 4'd4;
    localparam logic [3:0] c_ALU_SLL = 4'd5;
    localparam logic [3:0] c_ALU_SRL = 4'd6;
    localparam logic [3:0] c_ALU_SRA = 4'd7;
    localparam logic [3:0] c_ALU_SLT = 4'd8;

    typedef struct packed {
        logic            valid;
        logic            illegal;
        logic [AW-1:0]   rd;
        logic [AW-1:0]   rs1;
        logic [AW-1:0]   rs2;
        logic [XLEN-1:0] rs1_data;
        logic [XLEN-1:0] rs2_data;
        logic [XLEN-1:0] imm;
        logic [3:0]      alu_op;
        logic            alu_src;
        logic            mem_rd;
        logic            mem_wr;
        logic            reg_wr;
        logic            is_branch;
        logic [1:0]      br_type;
        logic [PC_W-1:0] pc;
        logic            pred_taken;
    } dec_t;

    logic [XLEN-1:0] r_rf [NREG];
    logic [NREG-1:0] r_sb;
    dec_t            r_out;

    logic [6:0]      w_opc;
    logic [2:0]      w_f3;
    logic            w_f7b5;
    logic [AW-1:0]   w_rd;
    logic [AW-1:0]   w_rs1;
    logic [AW-1:0]   w_rs2;
    logic            w_is_r, w_is_opi, w_is_ld, w_is_st, w_is_br, w_is_jal, w_is_jalr;
    logic            w_legal;
    logic            w_rs1_use, w_rs2_use;
    logic [XLEN-1:0] w_rs1_data, w_rs2_data;
    logic [NREG-1:0] w_sb_clr, w_sb_eff, w_sb_set;
    logic            w_hazard, w_issue;
    dec_t            w_dec;

    assign w_opc  = in_instr[6:0];
    assign w_f3   = in_instr[14:12];
    assign w_f7b5 = in_instr[30];
    assign w_rd   = in_instr[7 +: AW];
    assign w_rs1  = in_instr[15 +: AW];
    assign w_rs2  = in_instr[20 +: AW];

    assign w_is_r    = (w_opc == c_OP_R);
    assign w_is_opi  = (w_opc == c_OP_IMM);
    assign w_is_ld   = (w_opc == c_OP_LOAD);
    assign w_is_st   = (w_opc == c_OP_STORE);
    assign w_is_br   = (w_opc == c_OP_BRANCH) && (w_f3[2:1] == 2'b00);
    assign w_is_jal  = (w_opc == c_OP_JAL);
    assign w_is_jalr = (w_opc == c_OP_JALR);
    assign w_legal   = w_is_r | w_is_opi | w_is_ld | w_is_st | w_is_br | w_is_jal | w_is_jalr;

    assign w_rs1_use = w_legal & ~w_is_jal;
    assign w_rs2_use = w_is_r | w_is_st | w_is_br;

    // Same-cycle load write-back releases its register before the hazard check.
    assign w_sb_clr = (wb_en && wb_is_load) ? ({{(NREG-1){1'b0}}, 1'b1} << wb_addr) : '0;
    assign w_sb_eff = r_sb & ~w_sb_clr;
    assign w_hazard = in_valid & ((w_rs1_use & w_sb_eff[w_rs1]) | (w_rs2_use & w_sb_eff[w_rs2]));
    assign in_ready = ~mem_stall & (flush | ~w_hazard);
    assign w_issue  = in_valid & ~mem_stall & ~flush & ~w_hazard;
    assign w_sb_set = (w_issue && w_is_ld && (w_rd != '0)) ? ({{(NREG-1){1'b0}}, 1'b1} << w_rd) : '0;

    // Register-file read with write-first bypass; x0 is hardwired to zero.
    always_comb begin
        w_rs1_data = r_rf[w_rs1];
        w_rs2_data = r_rf[w_rs2];
        if (wb_en && (wb_addr == w_rs1)) w_rs1_data = wb_data;
        if (wb_en && (wb_addr == w_rs2)) w_rs2_data = wb_data;
        if (w_rs1 == '0) w_rs1_data = '0;
        if (w_rs2 == '0) w_rs2_data = '0;
    end

    // Full decode of the presented instruction; illegal opcodes keep only pc/pred.
    always_comb begin
        w_dec            = '0;
        w_dec.valid      = 1'b1;
        w_dec.illegal    = ~w_legal;
        w_dec.pc         = in_pc;
        w_dec.pred_taken = in_pred_taken;
        if (w_legal) begin
            w_dec.rd        = w_rd;
            w_dec.rs1       = w_rs1;
            w_dec.rs2       = w_rs2;
            w_dec.rs1_data  = w_rs1_data;
            w_dec.rs2_data  = w_rs2_data;
            w_dec.alu_src   = ~(w_is_r | w_is_br);
            w_dec.mem_rd    = w_is_ld;
            w_dec.mem_wr    = w_is_st;
            w_dec.reg_wr    = (w_is_r | w_is_opi | w_is_ld | w_is_jal | w_is_jalr) && (w_rd != '0);
            w_dec.is_branch = w_is_br | w_is_jal | w_is_jalr;
            w_dec.br_type   = w_is_jalr ? 2'd1 : (w_is_br ? {1'b1, w_f3[0]} : 2'd0);
            if (w_is_st)
                w_dec.imm = {{(XLEN-12){in_instr[31]}}, in_instr[31:25], in_instr[11:7]};
            else if (w_is_br)
                w_dec.imm = {{(XLEN-12){in_instr[31]}}, in_instr[7], in_instr[30:25], in_instr[11:8], 1'b0};
            else if (w_is_jal)
                w_dec.imm = {{(XLEN-20){in_instr[31]}}, in_instr[19:12], in_instr[20], in_instr[30:21], 1'b0};
            else if (!w_is_r)
                w_dec.imm = {{(XLEN-12){in_instr[31]}}, in_instr[31:20]};
            w_dec.alu_op = c_ALU_ADD;
            if (w_is_br) begin
                w_dec.alu_op = c_ALU_SUB;
            end else if (w_is_r || w_is_opi) begin
                case (w_f3)
                    3'b000:  w_dec.alu_op = (w_is_r && w_f7b5) ? c_ALU_SUB : c_ALU_ADD;
                    3'b001:  w_dec.alu_op = c_ALU_SLL;
                    3'b010:  w_dec.alu_op = c_ALU_SLT;
                    3'b100:  w_dec.alu_op = c_ALU_XOR;
                    3'b101:  w_dec.alu_op = w_f7b5 ? c_ALU_SRA : c_ALU_SRL;
                    3'b110:  w_dec.alu_op = c_ALU_OR;
                    3'b111:  w_dec.alu_op = c_ALU_AND;
                    default: w_dec.alu_op = c_ALU_ADD;
                endcase
            end
        end
    end

    // Register file: written on every write-back, stall or not; x0 never written.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < NREG; i++) r_rf[i] <= '0;
        end else if (wb_en && (wb_addr != '0)) begin
            r_rf[wb_addr] <= wb_data;
        end
    end

    // Scoreboard: clears always apply, sets only on issue; a set beats a clear.
    always_ff @(posedge clk) begin
        if (!rst_n) r_sb <= '0;
        else        r_sb <= w_sb_eff | w_sb_set;
    end

    // Output register: hold on stall, load on issue, otherwise a zero bubble.
    always_ff @(posedge clk) begin
        if (!rst_n)         r_out <= '0;
        else if (mem_stall) r_out <= r_out;
        else if (w_issue)   r_out <= w_dec;
        else                r_out <= '0;
    end

    assign out_valid      = r_out.valid;
    assign out_illegal    = r_out.illegal;
    assign out_rd         = r_out.rd;
    assign out_rs1        = r_out.rs1;
    assign out_rs2        = r_out.rs2;
    assign out_rs1_data   = r_out.rs1_data;
    assign out_rs2_data   = r_out.rs2_data;
    assign out_imm        = r_out.imm;
    assign out_alu_op     = r_out.alu_op;
    assign out_alu_src    = r_out.alu_src;
    assign out_mem_rd     = r_out.mem_rd;
    assign out_mem_wr     = r_out.mem_wr;
    assign out_reg_wr     = r_out.reg_wr;
    assign out_is_branch  = r_out.is_branch;
    assign out_br_type    = r_out.br_type;
    assign out_pc         = r_out.pc;
    assign out_pred_taken = r_out.pred_taken;

endmodule
`default_nettype wire
